// File: rtl/fc_l2_arb_pkg.sv
// rtl/fc_l2_arb_pkg.sv - shared widths, defaults and requester ID type for the FC L2 port arbiter
// Contents: L2 address/data/byte-enable widths, default requester count and
// outstanding depth, requester ID typedef sized for the default requester count.
package fc_l2_arb_pkg;

  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned BE_W          = 4;
  localparam int unsigned N_REQ_DEF     = 5;
  localparam int unsigned MAX_OUTST_DEF = 4;

  typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;

endpackage

// File: rtl/fc_l2_port_arbiter_if.sv
// rtl/fc_l2_port_arbiter_if.sv - requester and L2 channel bundle for the FC L2 port arbiter
// Signals: per-requester req/add/wen/wdata/be in, gnt/r_valid out, broadcast
// r_rdata/r_opc out; shared L2 request channel out, L2 grant/response in.
// Modports: slave = arbiter side, master = requesters plus L2 memory side.
interface fc_l2_port_arbiter_if #(
  parameter int unsigned N_REQ = fc_l2_arb_pkg::N_REQ_DEF
);
  import fc_l2_arb_pkg::*;

  logic [N_REQ-1:0]             req_i;
  logic [N_REQ-1:0][ADDR_W-1:0] add_i;
  logic [N_REQ-1:0]             wen_i;
  logic [N_REQ-1:0][DATA_W-1:0] wdata_i;
  logic [N_REQ-1:0][BE_W-1:0]   be_i;
  logic [N_REQ-1:0]             gnt_o;
  logic [N_REQ-1:0]             r_valid_o;
  logic [DATA_W-1:0]            r_rdata_o;
  logic                         r_opc_o;

  logic                         l2_req_o;
  logic [ADDR_W-1:0]            l2_add_o;
  logic                         l2_wen_o;
  logic [DATA_W-1:0]            l2_wdata_o;
  logic [BE_W-1:0]              l2_be_o;
  logic                         l2_gnt_i;
  logic                         l2_r_valid_i;
  logic [DATA_W-1:0]            l2_r_rdata_i;
  logic                         l2_r_opc_i;

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i,
    output gnt_o, r_valid_o, r_rdata_o, r_opc_o,
    output l2_req_o, l2_add_o, l2_wen_o, l2_wdata_o, l2_be_o,
    input  l2_gnt_i, l2_r_valid_i, l2_r_rdata_i, l2_r_opc_i
  );

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i,
    input  gnt_o, r_valid_o, r_rdata_o, r_opc_o,
    input  l2_req_o, l2_add_o, l2_wen_o, l2_wdata_o, l2_be_o,
    output l2_gnt_i, l2_r_valid_i, l2_r_rdata_i, l2_r_opc_i
  );

endinterface

// File: rtl/fc_l2_arb_id_fifo.sv
// rtl/fc_l2_arb_id_fifo.sv - in-order requester ID FIFO routing L2 responses back
// Ports: clk_i, rst_ni (sync, active-low); push_i/din_i write side;
// pop_i/dout_o read side (dout_o is the head); full_o, empty_o, count_o occupancy.
module fc_l2_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem[rd_q];

  // Guarding here keeps the FIFO safe even if a caller ignores full/empty.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage holds no state that matters after reset: the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) mem[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fc_l2_port_arbiter.sv
// rtl/fc_l2_port_arbiter.sv - round-robin arbiter of FC core and HWPE ports onto one L2 port
// Ports: clk_i, rst_ni (sync, active-low); bus (slave modport) carrying the
// requester channels and the shared L2 channel; busy_o = transactions
// outstanding; err_o = sticky flag for a response with nothing outstanding.
module fc_l2_port_arbiter
  import fc_l2_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = N_REQ_DEF,
  parameter int unsigned MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  fc_l2_port_arbiter_if.slave   bus,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;
  localparam int          NR    = int'(N_REQ);

  logic [ID_W-1:0]  rr_q, sel, head;
  logic [CNT_W-1:0] occ;
  logic             full, empty, hs, pop, err_q;

  // First requester at or above rr_q, wrapping. Scanning downward lets the
  // closest match overwrite farther ones, so no found flag is needed.
  always_comb begin
    int idx;
    sel = rr_q;
    for (int k = NR - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NR;
      if (bus.req_i[ID_W'(idx)]) sel = ID_W'(idx);
    end
  end

  // Reset gating keeps the L2 port and requesters quiet while state is cleared.
  assign bus.l2_req_o   = rst_ni & (|bus.req_i) & ~full;
  assign hs             = bus.l2_req_o & bus.l2_gnt_i;
  assign pop            = rst_ni & bus.l2_r_valid_i & ~empty;

  assign bus.l2_add_o   = bus.add_i[sel];
  assign bus.l2_wen_o   = bus.wen_i[sel];
  assign bus.l2_wdata_o = bus.wdata_i[sel];
  assign bus.l2_be_o    = bus.be_i[sel];
  assign bus.r_rdata_o  = bus.l2_r_rdata_i;
  assign bus.r_opc_o    = bus.l2_r_opc_i;

  always_comb begin
    bus.gnt_o     = '0;
    bus.r_valid_o = '0;
    if (hs)  bus.gnt_o[sel]      = 1'b1;
    if (pop) bus.r_valid_o[head] = 1'b1;
  end

  fc_l2_arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (ID_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .din_i   (sel),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occ)
  );

  // rr_q only moves on a handshake, so a stalled choice stays put.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (hs) rr_q <= (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
      if (bus.l2_r_valid_i && empty) err_q <= 1'b1;
    end
  end

  assign busy_o = (occ != '0);
  assign err_o  = err_q;

endmodule
